// File: rtl/fb_pkg.sv
// fb_pkg: shared framebuffer definitions for the fill engine and the VGA
// scanout. Both sides import this package so that resolution, address width
// and pixel format stay in one place.
//   FB_H_RES / FB_V_RES : framebuffer geometry (280 x 192)
//   FB_ADDR_W           : RAM address width
//   FB_DATA_W           : pixel width, RGB888 with R in [23:16]
package fb_pkg;

    localparam int FB_H_RES  = 280;
    localparam int FB_V_RES  = 192;
    localparam int FB_ADDR_W = 16;
    localparam int FB_DATA_W = 24;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        FILL
    } fb_wr_state_t;

endpackage

// File: rtl/fb_writer_if.sv
// fb_writer_if: command handshake plus framebuffer write port of the
// rectangle-fill engine.
//   master : command source / RAM arbiter side (drives cmd_*, wr_allow)
//   slave  : fill engine side (drives cmd_ready, fb_*, busy, cmd_err)
interface fb_writer_if;
    import fb_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [8:0]           cmd_x;
    logic [7:0]           cmd_y;
    logic [8:0]           cmd_w;
    logic [7:0]           cmd_h;
    logic [FB_DATA_W-1:0] cmd_color;
    logic                 wr_allow;
    logic [FB_ADDR_W-1:0] fb_adr;
    logic [FB_DATA_W-1:0] fb_d;
    logic                 fb_we;
    logic                 busy;
    logic                 cmd_err;

    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, wr_allow,
        input  cmd_ready, fb_adr, fb_d, fb_we, busy, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, wr_allow,
        output cmd_ready, fb_adr, fb_d, fb_we, busy, cmd_err
    );

endinterface

// File: rtl/fb_addr_calc.sv
// fb_addr_calc: combinational pixel (x, y) to framebuffer address.
// The row multiply by 280 is done as (y<<8)+(y<<4)+(y<<3) in 17 bits and
// then truncated to ADDR_W; the largest address (53759) fits in 16 bits.
// Shared with the scanout side.
//   x   : column (9 bits)
//   y   : row (8 bits)
//   adr : y*280 + x
module fb_addr_calc
    import fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W
) (
    input  logic [8:0]        x,
    input  logic [7:0]        y,
    output logic [ADDR_W-1:0] adr
);

    logic [16:0] y_ext;
    logic [16:0] y_mul;

    always_comb begin
        y_ext = {9'b0, y};
        y_mul = (y_ext << 8) + (y_ext << 4) + (y_ext << 3);
        adr   = ADDR_W'(y_mul) + ADDR_W'(x);
    end

endmodule

// File: rtl/fb_writer.sv
// fb_writer: rectangle-fill engine for the 280x192 RGB888 framebuffer.
// Accepts one fill command at a time, clips/validates it in a SETUP cycle,
// then writes the rectangle in raster order at one pixel per cycle whenever
// wr_allow indicates the scanout is off the RAM.
//
// Build option: define FB_WRITER_CLIP_EN to clamp rectangles to the visible
// area. Without it, out-of-range rectangles are dropped with a one-cycle
// cmd_err pulse.
//
// Ports:
//   CLOCK_50 : clock
//   reset    : synchronous, active-low reset
//   bus      : fb_writer_if.slave (command handshake, wr_allow, RAM write
//              port fb_adr/fb_d/fb_we, busy, cmd_err); all outputs registered
module fb_writer
    import fb_pkg::*;
#(
    parameter int H_RES  = FB_H_RES,
    parameter int V_RES  = FB_V_RES,
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = FB_DATA_W
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    fb_writer_if.slave  bus
);

    // Sums are one bit wider than the operands so they cannot overflow.
    localparam logic [9:0] X_END_MAX = 10'(H_RES);
    localparam logic [8:0] Y_END_MAX = 9'(V_RES);
    localparam logic [8:0] H_RES_9   = 9'(H_RES);
    localparam logic [7:0] V_RES_8   = 8'(V_RES);

    fb_wr_state_t      state;
    logic              ready_r;
    logic              busy_r;
    logic              we_r;
    logic              err_r;
    logic [ADDR_W-1:0] adr_r;
    logic [DATA_W-1:0] d_r;

    logic [8:0]        x_r;
    logic [7:0]        y_r;
    logic [8:0]        w_r;
    logic [7:0]        h_r;
    logic [DATA_W-1:0] color_r;
    logic [8:0]        col;
    logic [7:0]        row;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] base_calc;

    logic [9:0]        x_end;
    logic [8:0]        y_end;
    logic [8:0]        w_eff;
    logic [7:0]        h_eff;
    logic              drop;
    logic              empty;

    fb_addr_calc #(
        .ADDR_W (ADDR_W)
    ) u_addr_calc (
        .x   (x_r),
        .y   (y_r),
        .adr (base_calc)
    );

    // Geometry check of the latched command, consumed in SETUP.
    always_comb begin
        x_end = {1'b0, x_r} + {1'b0, w_r};
        y_end = {1'b0, y_r} + {1'b0, h_r};
        w_eff = w_r;
        h_eff = h_r;
        drop  = 1'b0;
`ifdef FB_WRITER_CLIP_EN
        // When x >= H_RES the difference wraps, but the command is empty then.
        if (x_end > X_END_MAX) w_eff = H_RES_9 - x_r;
        if (y_end > Y_END_MAX) h_eff = V_RES_8 - y_r;
`else
        drop = (x_end > X_END_MAX) || (y_end > Y_END_MAX);
`endif
        empty = (w_eff == 9'd0) || (h_eff == 8'd0) ||
                (x_r >= H_RES_9) || (y_r >= V_RES_8);
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state   <= IDLE;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            we_r    <= 1'b0;
            err_r   <= 1'b0;
            adr_r   <= '0;
            d_r     <= '0;
        end else begin
            we_r  <= 1'b0;
            err_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && ready_r) begin
                        x_r     <= bus.cmd_x;
                        y_r     <= bus.cmd_y;
                        w_r     <= bus.cmd_w;
                        h_r     <= bus.cmd_h;
                        color_r <= bus.cmd_color;
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                        state   <= SETUP;
                    end else begin
                        // Ready rises one cycle after the engine lands in IDLE.
                        ready_r <= 1'b1;
                    end
                end
                SETUP: begin
                    if (empty || drop) begin
                        err_r  <= drop && !empty;
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        w_r      <= w_eff;
                        h_r      <= h_eff;
                        row_base <= base_calc;
                        col      <= 9'd0;
                        row      <= 8'd0;
                        state    <= FILL;
                    end
                end
                FILL: begin
                    if (bus.wr_allow) begin
                        we_r  <= 1'b1;
                        adr_r <= row_base + ADDR_W'(col);
                        d_r   <= color_r;
                        if (col == w_r - 9'd1) begin
                            col      <= 9'd0;
                            row_base <= row_base + ADDR_W'(H_RES);
                            if (row == h_r - 8'd1) begin
                                busy_r <= 1'b0;
                                state  <= IDLE;
                            end else begin
                                row <= row + 8'd1;
                            end
                        end else begin
                            col <= col + 9'd1;
                        end
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = ready_r;
    assign bus.busy      = busy_r;
    assign bus.fb_we     = we_r;
    assign bus.fb_adr    = adr_r;
    assign bus.fb_d      = d_r;
    assign bus.cmd_err   = err_r;

endmodule

// File: tb/tb_fb_writer.sv
// tb_fb_writer: scoreboard bench for fb_writer. Expected writes are derived
// per pixel from the rectangle geometry and queued when a command is issued;
// a monitor on the falling edge pops and compares every RAM write and every
// cmd_err pulse. Directed cases cover latency, ordering, stalls, clipping,
// empty commands and mid-fill reset; a randomized phase follows.
module tb_fb_writer;
    import fb_pkg::*;

    logic CLOCK_50 = 1'b0;
    logic reset;

    fb_writer_if bus();

    fb_writer dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    logic [39:0] exp_q[$];
    int          exp_err = 0;
    int          err_seen = 0;
    int          wr_cyc_q[$];
    bit          rand_allow = 1'b0;
    logic [39:0] mon_e;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, req);
    endtask

    // Monitor / scoreboard.
    always @(negedge CLOCK_50) begin
        if (bus.fb_we === 1'b1) begin
            wr_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_write: actual adr %0d data %0h, required no write",
                         bus.fb_adr, bus.fb_d);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_adr", 64'(bus.fb_adr), 64'(mon_e[39:24]));
                chk("wr_data", 64'(bus.fb_d), 64'(mon_e[23:0]));
            end
        end
        if (bus.cmd_err === 1'b1) begin
            err_seen++;
            chk("err_expected", (exp_err > 0) ? 64'd1 : 64'd0, 64'd1);
            if (exp_err > 0) exp_err--;
        end
    end

    // Reference: enumerate every pixel of the rectangle and keep visible ones.
    task automatic model_cmd(input int x, input int y, input int w, input int h,
                             input logic [23:0] col);
        if (w == 0 || h == 0 || x >= FB_H_RES || y >= FB_V_RES) return;
`ifndef FB_WRITER_CLIP_EN
        if ((x + w > FB_H_RES) || (y + h > FB_V_RES)) begin
            exp_err++;
            return;
        end
`endif
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                if ((x + c < FB_H_RES) && (y + r < FB_V_RES))
                    exp_q.push_back({16'((y + r) * FB_H_RES + x + c), col});
    endtask

    task automatic send_cmd(input int x, input int y, input int w, input int h,
                            input logic [23:0] col, output int acc);
        int t;
        t = 0;
        while (bus.cmd_ready !== 1'b1 && t < 3000) begin
            @(posedge CLOCK_50); #1;
            t++;
        end
        chk("ready_before_cmd", 64'(bus.cmd_ready), 64'd1);
        model_cmd(x, y, w, h, col);
        bus.cmd_valid = 1'b1;
        bus.cmd_x     = 9'(x);
        bus.cmd_y     = 8'(y);
        bus.cmd_w     = 9'(w);
        bus.cmd_h     = 8'(h);
        bus.cmd_color = col;
        @(posedge CLOCK_50); #1;
        acc = cyc;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (bus.cmd_ready !== 1'b1 && t < 3000) begin
            @(posedge CLOCK_50); #1;
            t++;
        end
        chk("idle_reached", 64'(bus.cmd_ready), 64'd1);
        chk("pending_writes", 64'(exp_q.size()), 64'd0);
        chk("pending_err", 64'(exp_err), 64'd0);
    endtask

    initial forever begin
        @(posedge CLOCK_50); #1;
        if (rand_allow) bus.wr_allow = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int e0;
        int t;
        int rx, ry, rw, rh;
        reset         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_x     = '0;
        bus.cmd_y     = '0;
        bus.cmd_w     = '0;
        bus.cmd_h     = '0;
        bus.cmd_color = '0;
        bus.wr_allow  = 1'b1;

        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("rst_ready", 64'(bus.cmd_ready), 64'd0);
        chk("rst_we", 64'(bus.fb_we), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_err", 64'(bus.cmd_err), 64'd0);
        chk("rst_adr", 64'(bus.fb_adr), 64'd0);
        chk("rst_d", 64'(bus.fb_d), 64'd0);
        reset = 1'b1;
        @(posedge CLOCK_50); #1;
        chk("ready_after_reset", 64'(bus.cmd_ready), 64'd1);

        // Single pixel: latency and ready return.
        wr_cyc_q.delete();
        send_cmd(0, 0, 1, 1, 24'hFF0000, acc);
        @(posedge CLOCK_50); #1;
        chk("t1_busy_acc1", 64'(bus.busy), 64'd1);
        @(posedge CLOCK_50); #1;
        chk("t1_ready_acc2", 64'(bus.cmd_ready), 64'd0);
        chk("t1_we_acc2", 64'(bus.fb_we), 64'd1);
        @(posedge CLOCK_50); #1;
        chk("t1_ready_acc3", 64'(bus.cmd_ready), 64'd1);
        chk("t1_nwrites", 64'(wr_cyc_q.size()), 64'd1);
        if (wr_cyc_q.size() > 0) chk("t1_wr_latency", 64'(wr_cyc_q[0] - acc), 64'd2);

        // 3x2 block, back-to-back raster writes.
        wr_cyc_q.delete();
        send_cmd(10, 2, 3, 2, 24'h12AB34, acc);
        wait_idle();
        chk("t2_nwrites", 64'(wr_cyc_q.size()), 64'd6);
        if (wr_cyc_q.size() == 6) chk("t2_span", 64'(wr_cyc_q[5] - wr_cyc_q[0]), 64'd5);

        // Same block with a 4-cycle wr_allow stall after the 2nd write.
        wr_cyc_q.delete();
        send_cmd(10, 2, 3, 2, 24'h00FF00, acc);
        repeat (3) @(posedge CLOCK_50);
        #1;
        bus.wr_allow = 1'b0;
        repeat (4) @(posedge CLOCK_50);
        #1;
        bus.wr_allow = 1'b1;
        wait_idle();
        chk("t3_nwrites", 64'(wr_cyc_q.size()), 64'd6);
        if (wr_cyc_q.size() == 6) begin
            chk("t3_first", 64'(wr_cyc_q[0] - acc), 64'd2);
            chk("t3_gap", 64'(wr_cyc_q[2] - wr_cyc_q[1]), 64'd5);
            chk("t3_tail", 64'(wr_cyc_q[5] - wr_cyc_q[2]), 64'd3);
        end

        // Rectangle hanging off the bottom-right corner.
        wr_cyc_q.delete();
        e0 = err_seen;
        send_cmd(278, 190, 5, 5, 24'h0000FF, acc);
        wait_idle();
`ifdef FB_WRITER_CLIP_EN
        chk("t4_nwrites", 64'(wr_cyc_q.size()), 64'd4);
        chk("t4_nerr", 64'(err_seen - e0), 64'd0);
`else
        chk("t4_nwrites", 64'(wr_cyc_q.size()), 64'd0);
        chk("t4_nerr", 64'(err_seen - e0), 64'd1);
`endif

        // Empty commands.
        wr_cyc_q.delete();
        send_cmd(10, 10, 0, 5, 24'hABCDEF, acc);
        @(posedge CLOCK_50); #1;
        chk("t5_ready_acc1", 64'(bus.cmd_ready), 64'd0);
        @(posedge CLOCK_50); #1;
        chk("t5_ready_acc2", 64'(bus.cmd_ready), 64'd1);
        send_cmd(300, 10, 4, 4, 24'hABCDEF, acc);
        wait_idle();
        chk("t5_nwrites", 64'(wr_cyc_q.size()), 64'd0);

        // Reset during the third row of a 4x4 fill.
        wr_cyc_q.delete();
        send_cmd(100, 50, 4, 4, 24'h5A5A5A, acc);
        t = 0;
        while (wr_cyc_q.size() < 10 && t < 100) begin
            @(posedge CLOCK_50); #1;
            t++;
        end
        chk("t6_reached_row3", 64'(wr_cyc_q.size()), 64'd10);
        reset = 1'b0;
        @(posedge CLOCK_50); #1;
        chk("t6_we_after_rst", 64'(bus.fb_we), 64'd0);
        chk("t6_busy_after_rst", 64'(bus.busy), 64'd0);
        chk("t6_ready_after_rst", 64'(bus.cmd_ready), 64'd0);
        chk("t6_discarded", 64'(exp_q.size()), 64'd5);
        exp_q.delete();
        repeat (2) @(posedge CLOCK_50);
        #1;
        reset = 1'b1;
        repeat (6) @(posedge CLOCK_50);
        #1;
        chk("t6_no_more_writes", 64'(wr_cyc_q.size()), 64'd11);
        wr_cyc_q.delete();
        send_cmd(5, 5, 2, 2, 24'h808080, acc);
        wait_idle();
        chk("t6_next_cmd_writes", 64'(wr_cyc_q.size()), 64'd4);

        // Randomized commands with random wr_allow.
        rand_allow = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(250, 299)) : int'($urandom_range(0, 279));
            ry = ($urandom_range(0, 3) == 0) ? int'($urandom_range(170, 199)) : int'($urandom_range(0, 191));
            rw = int'($urandom_range(0, 24));
            rh = int'($urandom_range(0, 10));
            send_cmd(rx, ry, rw, rh, 24'($urandom), acc);
            wait_idle();
        end
        rand_allow   = 1'b0;
        bus.wr_allow = 1'b1;
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fb_writer.md
# fb_writer

Rectangle-fill engine that writes 24-bit RGB pixels into the 280x192 framebuffer RAM, the same RAM the VGA scanout reads. It accepts fill commands (x, y, width, height, colour) over a valid/ready handshake, clips them, and emits one RAM write per cycle. Writes happen only while the scanout side signals that it is off the RAM (`wr_allow`).

## Interface
- `H_RES`, 280, framebuffer width in pixels
- `V_RES`, 192, framebuffer height in pixels
- `ADDR_W`, 16, framebuffer address width
- `DATA_W`, 24, pixel width, RGB888 with R in [23:16]

Ports:
- `CLOCK_50`  in  1  sole clock
- `reset`  in  1  synchronous, active-low reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  engine idle, command accepted on `cmd_valid & cmd_ready`
- `cmd_x`  in  9  left column
- `cmd_y`  in  8  top row
- `cmd_w`  in  9  width in pixels
- `cmd_h`  in  8  height in rows
- `cmd_color`  in  DATA_W  fill colour
- `wr_allow`  in  1  RAM free for writing (scanout in blanking)
- `fb_adr`  out  ADDR_W  RAM address
- `fb_d`  out  DATA_W  RAM write data
- `fb_we`  out  1  RAM write enable
- `busy`  out  1  command in progress
- `cmd_err`  out  1  one-cycle pulse: command rejected

## Operation
- States: IDLE, SETUP, FILL.
- IDLE: `cmd_ready`=1. On handshake, latch all `cmd_*` fields and go to SETUP.
- SETUP (1 cycle):
  - Clip the rectangle (see Configuration).
  - Empty result (w=0, h=0, or x≥H_RES, or y≥V_RES): return to IDLE, no writes.
  - Otherwise `row_base = y*H_RES + x`, col=0, row=0, go to FILL.
- FILL, each cycle with `wr_allow`=1:
  - Drive `fb_adr` = row_base+col, `fb_d` = colour, `fb_we`=1.
  - Increment col. When col reaches w−1: col=0, row_base += H_RES, row++.
  - After the last pixel (col=w−1, row=h−1), go to IDLE.
- FILL with `wr_allow`=0: stall. Counters hold, `fb_we`=0.
- Pixel order: raster, left to right, then top to bottom.
- `busy` = state≠IDLE.
- Arithmetic:
  - y*H_RES is computed as (y<<8)+(y<<4)+(y<<3) in 17 bits, then truncated to ADDR_W.
  - Maximum address is 53759, so no wrap occurs.
  - x+w and y+h are evaluated 1 bit wider than the operands, so sums cannot overflow.

## Timing
- Outputs are registered. Reset values: `cmd_ready`=0 during reset and 1 in the first cycle after reset deasserts; all other outputs 0.
- First `fb_we` is 2 cycles after the accepting edge, if `wr_allow`=1.
- Throughput is 1 pixel/cycle. A w×h fill with `wr_allow` held high takes w·h+2 cycles from accept to `cmd_ready`=1.
- `wr_allow` is sampled in the same cycle the write is issued. When it falls, `fb_we` is 0 on the next registered output.
- `cmd_ready`=0 from the accepting cycle until the state returns to IDLE. No command queueing.
- `reset` asserted mid-FILL: abort immediately, remaining pixels are discarded, all outputs go to their reset values on the next edge.

## Configuration
- Macro: `FB_WRITER_CLIP_EN`.
- Defined:
  - In SETUP, w is clamped to min(w, H_RES−x) and h to min(h, V_RES−y).
  - Partially visible rectangles are drawn as their visible part.
  - `cmd_err` is tied 0.
- Undefined:
  - No clamp logic is built.
  - A command with x+w>H_RES or y+h>V_RES is dropped in SETUP, `cmd_err` pulses for 1 cycle, and the engine returns to IDLE with no writes.
  - In-range commands behave identically to the defined case.

## Structure
- Package `fb_pkg` holds:
  - `FB_H_RES`, `FB_V_RES`, `FB_ADDR_W`, `FB_DATA_W`
  - `rgb888_t` packed struct (r, g, b)
  - `fb_wr_state_t` enum (IDLE, SETUP, FILL)
  - The scanout module is to import `fb_pkg` as well.
- Sub-module `fb_addr_calc`: combinational (x, y) → address via shift-add. It is reusable by the scanout side.

## Test plan
- `wr_allow`=1, cmd (x=0, y=0, w=1, h=1, colour 0xFF0000) → single write, adr 0, d 0xFF0000, on cycle accept+2; `cmd_ready` returns on accept+3.
- cmd (x=10, y=2, w=3, h=2) → writes at addresses 570, 571, 572, 850, 851, 852, in order.
- Same cmd with `wr_allow` low for 4 cycles after the 2nd write → exactly 6 writes, with a 4-cycle gap and no duplicates.
- cmd (x=278, y=190, w=5, h=5):
  - With CLIP_EN: writes at addresses 53478, 53479, 53758, 53759.
  - Without CLIP_EN: zero writes and one `cmd_err` pulse.
- cmd with w=0 → no writes, `cmd_ready` back after 2 cycles; cmd with x=300 → no writes.
- `reset` low during the 3rd row of a 4×4 fill → `fb_we`=0 on the next edge, no further writes after release, and the next command executes normally.
